// File: rtl/multi_buffer_loader.sv
// multi_buffer_loader: framed byte-stream parser that writes words into one of several buffers,
// with burst addressing, XOR checksum, inter-byte timeout, error codes and a start pulse.
module multi_buffer_loader #(
    parameter int          NUM_BUFS       = 2,
    parameter int          ADDR_WIDTH     = 10,
    parameter int          DATA_WIDTH     = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [NUM_BUFS-1:0]   wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  start_matmul,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [2:0]            err_code,
    output logic                  busy
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CMD, AHI, ALO, LHI, LLO, DATA, CSUM} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           len_q, len_d;
    logic [5:0]            id_q, id_d;
    logic                  start_cmd_q, start_cmd_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [NUM_BUFS-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  start_q, start_d, ok_q, ok_d, err_q, err_d;
    logic [2:0]            code_q, code_d;
    logic                  timeout, wdone, bad_buf;

    assign timeout = state_q != IDLE && !rx_valid && tmr_q == TW'(TIMEOUT_CYCLES - 1);
    assign wdone   = bcnt_q == BW'(BPW - 1);
    assign bad_buf = {1'b0, id_q} >= 7'(NUM_BUFS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            start_cmd_q <= 1'b0;
            bcnt_q      <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            tmr_q       <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            start_q     <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            start_cmd_q <= start_cmd_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            tmr_q       <= tmr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            start_q     <= start_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout)
            state_d = IDLE;
        else if (rx_valid)
            case (state_q)
                IDLE:    state_d = rx_data == SYNC_BYTE ? CMD : IDLE;
                CMD:     state_d = rx_data[7] ? IDLE : rx_data[6] ? CSUM : AHI;
                AHI:     state_d = ALO;
                ALO:     state_d = LHI;
                LHI:     state_d = LLO;
                LLO:     state_d = {len_q[7:0], rx_data} == 16'h0 ? IDLE : DATA;
                DATA:    state_d = wdone && len_q == 16'h1 ? CSUM : DATA;
                default: state_d = IDLE;
            endcase
    end

    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        start_cmd_d = start_cmd_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        start_d     = 1'b0;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        tmr_d       = (state_q == IDLE || rx_valid) ? '0 : tmr_q + 1'b1;
        if (timeout) begin
            err_d  = 1'b1;
            code_d = 3'd3;
        end else if (rx_valid) begin
            csum_d = state_q == IDLE ? 8'h00 : csum_q ^ rx_data;
            case (state_q)
                CMD: begin
                    id_d        = rx_data[5:0];
                    start_cmd_d = rx_data[6];
                    err_d       = rx_data[7];
                    code_d      = rx_data[7] ? 3'd4 : code_q;
                end
                AHI: addr_d = ADDR_WIDTH'({rx_data, 8'h00});
                ALO: addr_d = addr_q | ADDR_WIDTH'(rx_data);
                LHI: len_d = {8'h00, rx_data};
                LLO: begin
                    len_d  = {len_q[7:0], rx_data};
                    bcnt_d = '0;
                    err_d  = len_d == 16'h0;
                    code_d = len_d == 16'h0 ? 3'd5 : code_q;
                end
                DATA: begin
                    word_d = (word_q << 8) | DATA_WIDTH'(rx_data);
                    bcnt_d = wdone ? '0 : bcnt_q + 1'b1;
                    if (wdone) begin
                        len_d     = len_q - 1'b1;
                        addr_d    = addr_q + 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_d;
                        wr_en_d   = bad_buf ? '0 : NUM_BUFS'(1) << id_q;
                    end
                end
                CSUM: begin
                    // A bad buffer id outranks a checksum mismatch
                    if (!start_cmd_q && bad_buf) begin
                        err_d  = 1'b1;
                        code_d = 3'd2;
                    end else if (rx_data != csum_q) begin
                        err_d  = 1'b1;
                        code_d = 3'd1;
                    end else begin
                        ok_d    = 1'b1;
                        start_d = start_cmd_q;
                        code_d  = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign start_matmul = start_q;
    assign frame_ok     = ok_q;
    assign frame_err    = err_q;
    assign err_code     = code_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_multi_buffer_loader.sv
// tb_multi_buffer_loader: scoreboard bench; expected writes and frame results are queued
// as frames are sent and compared when the DUT pulses them.
module tb_multi_buffer_loader;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start_matmul, frame_ok, frame_err, busy;
    logic [2:0]  err_code;

    int vecs = 0;
    int miscompares = 0;
    logic [27:0] exp_w[$];
    logic [5:0]  exp_ev[$];
    logic [15:0] wq[$];

    multi_buffer_loader #(
        .NUM_BUFS(2), .ADDR_WIDTH(10), .DATA_WIDTH(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start_matmul(start_matmul),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ev(input bit ok, input bit err, input bit st, input logic [2:0] code);
        return {ok, err, st, code};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en != 2'b00) begin
                if (exp_w.size() == 0) check("wr_unexpected", {4'h0, wr_en, wr_addr, wr_data}, 32'h0);
                else check("write", {4'h0, wr_en, wr_addr, wr_data}, {4'h0, exp_w.pop_front()});
            end
            if (frame_ok || frame_err || start_matmul) begin
                if (exp_ev.size() == 0) check("frame_unexpected", {frame_ok, frame_err, start_matmul, err_code}, 32'h0);
                else check("frame", {frame_ok, frame_err, start_matmul, err_code}, exp_ev.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_write(input logic [7:0] cmd, input logic [15:0] addr, input bit bad);
        logic [7:0]  cs;
        logic [15:0] len;
        logic [5:0]  id;
        len = 16'(wq.size());
        id  = cmd[5:0];
        cs  = cmd ^ addr[15:8] ^ addr[7:0] ^ len[15:8] ^ len[7:0];
        foreach (wq[k]) begin
            cs = cs ^ wq[k][15:8] ^ wq[k][7:0];
            if (id < 2) exp_w.push_back({2'b01 << id, 10'(addr + 16'(k)), wq[k]});
        end
        exp_ev.push_back(id >= 2 ? ev(0, 1, 0, 3'd2) : bad ? ev(0, 1, 0, 3'd1) : ev(1, 0, 0, 3'd0));
        send_byte(8'hA5, $urandom_range(0, 1));
        send_byte(cmd, $urandom_range(0, 1));
        send_byte(addr[15:8], $urandom_range(0, 1));
        send_byte(addr[7:0], $urandom_range(0, 1));
        send_byte(len[15:8], $urandom_range(0, 1));
        send_byte(len[7:0], $urandom_range(0, 1));
        foreach (wq[k]) begin
            send_byte(wq[k][15:8], $urandom_range(0, 1));
            send_byte(wq[k][7:0], $urandom_range(0, 1));
        end
        send_byte(bad ? ~cs : cs, 0);
        repeat (3) tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_pulses"}, {start_matmul, frame_ok, frame_err}, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (2) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        wq = '{16'h1234, 16'h5678};
        send_write(8'h00, 16'h0010, 0);
        check("t1_err_code", err_code, 0);

        exp_ev.push_back(ev(1, 0, 1, 3'd0));
        send_byte(8'hA5, 0); send_byte(8'h41, 0); send_byte(8'h41, 3);
        exp_ev.push_back(ev(0, 1, 0, 3'd1));
        send_byte(8'hA5, 1); send_byte(8'h41, 1); send_byte(8'h00, 3);
        check("t2_err_code", err_code, 1);

        wq = '{16'h1111, 16'h2222};
        send_write(8'h01, 16'h03FF, 0);

        wq = '{16'hABCD};
        send_write(8'h05, 16'h0000, 0);
        check("t4_bad_buf_code", err_code, 2);
        wq = '{16'hA5A5, 16'h00FF};
        send_write(8'h00, 16'h0100, 0);
        check("t4_recover_code", err_code, 0);

        exp_ev.push_back(ev(0, 1, 0, 3'd4));
        send_byte(8'h33, 0); send_byte(8'hA5, 0); send_byte(8'h80, 3);
        check("opcode_busy", busy, 0);
        exp_ev.push_back(ev(0, 1, 0, 3'd5));
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 3);
        check("len0_busy", busy, 0);

        wq = '{16'hBEEF};
        send_write(8'h01, 16'h0200, 1);

        exp_ev.push_back(ev(0, 1, 0, 3'd3));
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
        check("t5_busy_wait", busy, 1);
        repeat (TO + 20) tick();
        check("t5_busy", busy, 0);
        check("t5_err_code", err_code, 3);
        check("t5_ev_seen", exp_ev.size(), 0);
        wq = '{16'h0F0F};
        send_write(8'h00, 16'h0005, 0);

        exp_w.push_back({2'b01, 10'h020, 16'h1234});
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
        send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wq = '{16'hCAFE, 16'hF00D, 16'h0001};
        send_write(8'h01, 16'h0040, 0);

        for (int f = 0; f < 6; f++) begin
            wq.delete();
            for (int w = 0; w < int'($urandom_range(1, 4)); w++) wq.push_back(16'($urandom));
            send_write({2'b00, 6'($urandom_range(0, 2))}, 16'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (5) tick();
        check("writes_drained", exp_w.size(), 0);
        check("frames_drained", exp_ev.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
